i2c_master_cmd: RTL and testbench

I2C_MASTER_CMD -- requirements
Module: i2c_master_cmd

---
 rtl/i2c_master_cmd_if.sv | 18 +
 rtl/i2c_master_cmd.sv | 183 ++++++++++++++++++
 tb/tb_i2c_master_cmd.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_cmd_if.sv
// Command/response handshake between a host and the i2c_master_cmd byte engine.
interface i2c_master_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ack;
  logic       rsp_err;
  logic       busy;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_nack,
                  input  cmd_ready, rsp_valid, rsp_data, rsp_ack, rsp_err, busy);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, cmd_nack,
                  output cmd_ready, rsp_valid, rsp_data, rsp_ack, rsp_err, busy);
endinterface

// File: rtl/i2c_master_cmd.sv
// Command-driven I2C/SCCB master: START/WRITE/READ/STOP, one byte per command.
// Optional slave clock stretching via macro I2C_CLK_STRETCH_EN (open-drain only).
module i2c_master_cmd #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int SCL_FREQ  = 100_000,
  parameter int PUSH_PULL = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  i2c_master_cmd_if.slave         cmd_if,
  inout  wire                     scl,
  inout  wire                     sda,
  output logic [3:0]              state
);
  localparam int QTR_RAW = CLK_FREQ / (4 * SCL_FREQ);
  localparam int QTR     = (QTR_RAW < 1) ? 1 : QTR_RAW;
  localparam int QW      = (QTR > 1) ? $clog2(QTR) : 1;

  localparam logic [1:0] OP_START = 2'd0, OP_WRITE = 2'd1, OP_READ = 2'd2, OP_STOP = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WRITE, S_WACK, S_READ, S_RACK, S_STOP, S_HOLD
  } state_e;

  state_e      state_q;
  logic [QW-1:0] qcnt_q;
  logic [1:0]  qtr_q;
  logic [2:0]  bit_q;
  logic [7:0]  shreg_q;
  logic        nack_q, rs_q, busy_q;
  logic        rsp_valid_q, rsp_err_q, rsp_ack_q;
  logic [7:0]  rsp_data_q;
  logic        scl_q, sda_q, rel_q;
  logic        scl_d, sda_d, rel_d;
  logic        sda_m_q, sda_s_q;
  logic        tick, stall, idle_like;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
    end else begin
      sda_m_q <= sda;
      sda_s_q <= sda_m_q;
    end
  end

`ifdef I2C_CLK_STRETCH_EN
  logic scl_m_q, scl_s_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
    end else begin
      scl_m_q <= scl;
      scl_s_q <= scl_m_q;
    end
  end
  // Q2 is the SCL-high quarter: wait there until the slave lets the line rise.
  assign stall = (PUSH_PULL == 0) && (qtr_q == 2'd2) && !scl_s_q;
`else
  assign stall = 1'b0;
`endif

  assign tick      = (qcnt_q == QW'(QTR - 1));
  assign idle_like = (state_q == S_IDLE) || (state_q == S_HOLD);

  // Line levels per state/quarter; registered below, so lines trail state by one clock.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    rel_d = 1'b0;
    case (state_q)
      S_START: begin
        scl_d = rs_q ? (qtr_q == 2'd1 || qtr_q == 2'd2) : 1'b1;
        sda_d = ~qtr_q[1];
      end
      S_WRITE: begin scl_d = qtr_q[1]; sda_d = shreg_q[7]; end
      S_WACK, S_READ: begin scl_d = qtr_q[1]; rel_d = 1'b1; end
      S_RACK:  begin scl_d = qtr_q[1]; sda_d = nack_q; end
      S_STOP:  begin scl_d = (qtr_q != 2'd0); sda_d = qtr_q[1]; end
      S_HOLD:  begin scl_d = 1'b0; sda_d = sda_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      qtr_q       <= 2'd0;
      bit_q       <= 3'd0;
      shreg_q     <= 8'h00;
      nack_q      <= 1'b0;
      rs_q        <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ack_q   <= 1'b0;
      rsp_data_q  <= 8'h00;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      rel_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      rel_q       <= rel_d;
      if (idle_like) begin
        qcnt_q <= '0;
        qtr_q  <= 2'd0;
        bit_q  <= 3'd0;
        if (cmd_if.cmd_valid) begin
          shreg_q <= cmd_if.cmd_data;
          nack_q  <= cmd_if.cmd_nack;
          if (cmd_if.cmd_op == OP_START) begin
            state_q <= S_START;
            rs_q    <= (state_q == S_HOLD);
            busy_q  <= 1'b1;
          end else if (state_q == S_IDLE) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            case (cmd_if.cmd_op)
              OP_WRITE: state_q <= S_WRITE;
              OP_READ:  state_q <= S_READ;
              default:  state_q <= S_STOP;
            endcase
          end
        end
      end else if (!stall) begin
        if (!tick) begin
          qcnt_q <= qcnt_q + QW'(1);
        end else begin
          qcnt_q <= '0;
          qtr_q  <= qtr_q + 2'd1;
          // ACK and read data both shift into shreg_q at the end of the high quarter.
          if (qtr_q == 2'd2 && (state_q == S_READ || state_q == S_WACK))
            shreg_q <= {shreg_q[6:0], sda_s_q};
          if (qtr_q == 2'd3) begin
            bit_q <= bit_q + 3'd1;
            case (state_q)
              S_START: begin state_q <= S_HOLD; rsp_valid_q <= 1'b1; end
              S_WRITE: begin
                shreg_q <= {shreg_q[6:0], 1'b0};
                if (bit_q == 3'd7) state_q <= S_WACK;
              end
              S_WACK: begin
                state_q     <= S_HOLD;
                rsp_valid_q <= 1'b1;
                rsp_ack_q   <= ~shreg_q[0];
              end
              S_READ: if (bit_q == 3'd7) state_q <= S_RACK;
              S_RACK: begin
                state_q     <= S_HOLD;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= shreg_q;
              end
              S_STOP: begin
                state_q     <= S_IDLE;
                rsp_valid_q <= 1'b1;
                busy_q      <= 1'b0;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      end
    end
  end

  assign scl = (PUSH_PULL != 0) ? scl_q : (scl_q ? 1'bz : 1'b0);
  assign sda = rel_q ? 1'bz : ((PUSH_PULL != 0) ? sda_q : (sda_q ? 1'bz : 1'b0));

  assign cmd_if.cmd_ready = idle_like;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_err   = rsp_err_q;
  assign cmd_if.rsp_ack   = rsp_ack_q;
  assign cmd_if.rsp_data  = rsp_data_q;
  assign cmd_if.busy      = busy_q;
  assign state            = state_q;
endmodule

// File: tb/tb_i2c_master_cmd.sv
// Directed bench for i2c_master_cmd: command table plus hand-written bus corner cases.
module tb_i2c_master_cmd;
  localparam logic [1:0] OP_START = 2'd0, OP_WRITE = 2'd1, OP_READ = 2'd2, OP_STOP = 2'd3;
`ifdef I2C_CLK_STRETCH_EN
  localparam int PER = 1003;
`else
  localparam int PER = 1000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  scl, sda;
  logic [3:0] state;
  logic sl_sda = 1'b1;
  logic sl_scl = 1'b1;

  i2c_master_cmd_if bus ();

  i2c_master_cmd dut (
    .clk(clk), .rst_n(rst_n), .cmd_if(bus), .scl(scl), .sda(sda), .state(state)
  );

  pullup (scl);
  pullup (sda);
  assign sda = sl_sda ? 1'bz : 1'b0;
  assign scl = sl_scl ? 1'bz : 1'b0;

  wire scl_l = (scl !== 1'b0);
  wire sda_l = (sda !== 1'b0);

  always #5 clk = ~clk;

  int   cyc = 0, nstart = 0, nstop = 0, nlow = 0, rsp_cnt = 0;
  logic lerr = 1'b0, scl_p = 1'b1, sda_p = 1'b1;
  int   n_chk = 0, n_pass = 0;

  // Bus monitor: START/STOP conditions, low-line activity, response pulses.
  always @(negedge clk) begin
    cyc   <= cyc + 1;
    scl_p <= scl_l;
    sda_p <= sda_l;
    if (scl_p && scl_l && sda_p && !sda_l) nstart <= nstart + 1;
    if (scl_p && scl_l && !sda_p && sda_l) nstop <= nstop + 1;
    if (!scl_l || !sda_l) nlow <= nlow + 1;
    if (bus.rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      lerr    <= bus.rsp_err;
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    logic       nk;
    logic       sack;
    logic [7:0] sbyte;
    logic       eack;
    logic [7:0] edata;
    logic       ebusy;
    logic [3:0] est;
    int         nst;
    int         nsp;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic wait_scl(input logic lvl);
    int n = 0;
    while (scl_l !== lvl && n < 4000) begin @(negedge clk); n++; end
    if (scl_l !== lvl) chk("scl_wait_timeout", 32'(scl_l), 32'(lvl));
  endtask

  task automatic wait_rsp(input int n0);
    for (int n = 0; n < 12000 && rsp_cnt == n0; n++) @(negedge clk);
    if (rsp_cnt == n0) chk("rsp_timeout", 32'(0), 32'(1));
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic nk);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_nack  = nk;
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic slave_write(input logic ack, input int stretch, output logic [7:0] b,
                             output int per, output int p5);
    int r[8];
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_scl(1'b1);
      r[i] = cyc;
      b = {b[6:0], sda_l};
      wait_scl(1'b0);
      if (stretch > 0 && i == 4) begin
        sl_scl = 1'b0;
        repeat (stretch) @(negedge clk);
        sl_scl = 1'b1;
      end
    end
    per = r[1] - r[0];
    p5  = r[5] - r[4];
    if (ack) sl_sda = 1'b0;
    wait_scl(1'b1);
    wait_scl(1'b0);
    sl_sda = 1'b1;
  endtask

  task automatic slave_read(input logic [7:0] by, output logic rack);
    for (int i = 0; i < 8; i++) begin
      sl_sda = by[7-i];
      wait_scl(1'b1);
      wait_scl(1'b0);
    end
    sl_sda = 1'b1;
    wait_scl(1'b1);
    rack = sda_l;
    wait_scl(1'b0);
  endtask

  initial begin
    int n0, per, p5, st0, lo0;
    logic [7:0] wb;
    logic rk;

    tbl[0]  = '{OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 4'd7, 1, 0};
    tbl[1]  = '{OP_WRITE, 8'h42, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 4'd7, 1, 0};
    tbl[2]  = '{OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0, 1, 1};
    tbl[3]  = '{OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 4'd7, 2, 1};
    tbl[4]  = '{OP_WRITE, 8'h43, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 4'd7, 2, 1};
    tbl[5]  = '{OP_READ,  8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 4'd7, 2, 1};
    tbl[6]  = '{OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 4'd0, 2, 2};
    tbl[7]  = '{OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 4'd7, 3, 2};
    tbl[8]  = '{OP_WRITE, 8'h84, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 4'd7, 3, 2};
    tbl[9]  = '{OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 4'd7, 4, 2};
    tbl[10] = '{OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 4'd0, 4, 3};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 8'h00;
    bus.cmd_nack  = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_state", 32'(state), 32'(0));
    chk("rst_scl", 32'(scl_l), 32'(1));
    chk("rst_sda", 32'(sda_l), 32'(1));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 32'(1));
    chk("rst_data", 32'(bus.rsp_data), 32'(0));
    chk("rst_ack", 32'(bus.rsp_ack), 32'(0));
    chk("rst_err", 32'(bus.rsp_err), 32'(0));

    // Command table
    for (int k = 0; k < 11; k++) begin
      n0 = rsp_cnt;
      issue(tbl[k].op, tbl[k].d, tbl[k].nk);
      if (tbl[k].op == OP_WRITE) begin
        slave_write(tbl[k].sack, 0, wb, per, p5);
        chk($sformatf("v%0d_sda_bits", k), 32'(wb), 32'(tbl[k].d));
        chk($sformatf("v%0d_scl_period", k), 32'(per), 32'(PER));
      end
      if (tbl[k].op == OP_READ) begin
        slave_read(tbl[k].sbyte, rk);
        chk($sformatf("v%0d_rack_sda", k), 32'(rk), 32'(tbl[k].nk));
      end
      wait_rsp(n0);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_pulses", k), 32'(rsp_cnt - n0), 32'(1));
      chk($sformatf("v%0d_ack", k), 32'(bus.rsp_ack), 32'(tbl[k].eack));
      chk($sformatf("v%0d_data", k), 32'(bus.rsp_data), 32'(tbl[k].edata));
      chk($sformatf("v%0d_err", k), 32'(lerr), 32'(0));
      chk($sformatf("v%0d_busy", k), 32'(bus.busy), 32'(tbl[k].ebusy));
      chk($sformatf("v%0d_state", k), 32'(state), 32'(tbl[k].est));
      chk($sformatf("v%0d_ready", k), 32'(bus.cmd_ready), 32'(1));
      chk($sformatf("v%0d_nstart", k), 32'(nstart), 32'(tbl[k].nst));
      chk($sformatf("v%0d_nstop", k), 32'(nstop), 32'(tbl[k].nsp));
    end

    // WRITE/READ/STOP while IDLE: error pulse one cycle after acceptance, bus untouched
    for (int op = 1; op < 4; op++) begin
      n0  = rsp_cnt;
      lo0 = nlow;
      issue(2'(op), 8'h00, 1'b0);
      chk($sformatf("idle_op%0d_valid", op), 32'(bus.rsp_valid), 32'(1));
      chk($sformatf("idle_op%0d_err", op), 32'(bus.rsp_err), 32'(1));
      @(negedge clk);
      chk($sformatf("idle_op%0d_pulse_end", op), 32'(bus.rsp_valid), 32'(0));
      repeat (10) @(negedge clk);
      chk($sformatf("idle_op%0d_state", op), 32'(state), 32'(0));
      chk($sformatf("idle_op%0d_busy", op), 32'(bus.busy), 32'(0));
      chk($sformatf("idle_op%0d_no_low", op), 32'(nlow - lo0), 32'(0));
      chk($sformatf("idle_op%0d_pulses", op), 32'(rsp_cnt - n0), 32'(1));
    end

`ifdef I2C_CLK_STRETCH_EN
    // Slave holds SCL low 1000 clk from the start of bit 5: 500 clk beyond the normal low phase
    n0 = rsp_cnt;
    issue(OP_START, 8'h00, 1'b0);
    wait_rsp(n0);
    n0 = rsp_cnt;
    issue(OP_WRITE, 8'h5A, 1'b0);
    slave_write(1'b1, 1000, wb, per, p5);
    wait_rsp(n0);
    @(negedge clk);
    chk("stretch_bits", 32'(wb), 32'h5A);
    chk("stretch_bit5_period", 32'(p5 >= 1501 && p5 <= 1505), 32'(1));
    chk("stretch_ack", 32'(bus.rsp_ack), 32'(1));
    n0 = rsp_cnt;
    issue(OP_STOP, 8'h00, 1'b0);
    wait_rsp(n0);
`endif

    // Reset during bit 3 of a WRITE releases both lines at once, no STOP on the bus
    n0 = rsp_cnt;
    issue(OP_START, 8'h00, 1'b0);
    wait_rsp(n0);
    issue(OP_WRITE, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_scl(1'b1);
      wait_scl(1'b0);
    end
    repeat (100) @(negedge clk);
    chk("midrst_pre_scl", 32'(scl_l), 32'(0));
    chk("midrst_pre_sda", 32'(sda_l), 32'(0));
    chk("midrst_pre_state", 32'(state), 32'(2));
    st0   = nstop;
    rst_n = 1'b0;
    #1;
    chk("midrst_scl", 32'(scl_l), 32'(1));
    chk("midrst_sda", 32'(sda_l), 32'(1));
    chk("midrst_state", 32'(state), 32'(0));
    chk("midrst_busy", 32'(bus.busy), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_stop", 32'(nstop - st0), 32'(0));
    chk("midrst_ready", 32'(bus.cmd_ready), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
